// File: rtl/shared_res_sched.sv
// Round-robin owner scheduler for a shared resource: one-hot grant, bounded
// hold time with forced revocation, and a mandatory idle gap between owners.
module shared_res_sched #(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             tmo
);

  // state  | meaning
  // S_IDLE | no owner; arbitrate among active requests
  // S_OWN  | grant held; hold counter runs while owner keeps req high
  // S_GAP  | single all-zero cycle after release or revocation
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_e;

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic             ready_q;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       id_q, id_d;
  logic             busy_q;
  logic             tmo_q, tmo_d;

  logic             win_vld;
  logic [1:0]       win_idx;
  logic [2:0]       cand;
  logic             own_req;
  logic             hold_done;

  // Search starts one past the previous owner and wraps.
  always_comb begin
    win_vld = 1'b0;
    win_idx = last_q;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, last_q} + 3'd1 + 3'(i);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (!win_vld && req[cand[1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[1:0];
      end
    end
  end

  assign own_req   = req[last_q];
  assign hold_done = (cnt_q == HOLD_LAST);

  // ready_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 2'(N_REQ - 1);
      ready_q <= 1'b0;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ready_q <= 1'b1;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      busy_q  <= |gnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (ready_q && win_vld) begin
          state_d = S_OWN;
          cnt_d   = '0;
          last_d  = win_idx;
        end
      end
      S_OWN: begin
        if (!own_req || hold_done) state_d = S_GAP;
        else                       cnt_d   = cnt_q + CW'(1);
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A release in the threshold cycle wins over the timeout.
  always_comb begin
    gnt_d = gnt_q;
    id_d  = id_q;
    tmo_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready_q && win_vld) begin
          gnt_d = ONE << win_idx;
          id_d  = win_idx;
        end
      end
      S_OWN: begin
        if (!own_req || hold_done) begin
          gnt_d = '0;
          id_d  = '0;
          tmo_d = own_req;
        end
      end
      default: begin
        gnt_d = '0;
        id_d  = '0;
      end
    endcase
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = busy_q;
  assign tmo    = tmo_q;

endmodule

// File: tb/tb_shared_res_sched.sv
// Bench for shared_res_sched: directed table, corner sequences, and random
// traffic compared against an ownership-level reference model.
module tb_shared_res_sched;

  localparam int N  = 3;
  localparam int MH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         tmo;

  int n_chk  = 0;
  int n_pass = 0;

  shared_res_sched #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: who owns, how long they have owned, how many edges
  // must pass with nobody granted before arbitration may happen again.
  int m_owner, m_held, m_cool, m_last;
  bit m_tmo;

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_cool = 1; m_last = N - 1; m_tmo = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    bit found;
    m_tmo = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_cool = 1;
      end else if (m_held == MH) begin
        m_owner = -1; m_cool = 1; m_tmo = 1;
      end else m_held++;
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && r[c]) begin
          found = 1; m_owner = c; m_last = c; m_held = 1;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_id", gnt_id, 0);
    check("rst_busy", busy, 0);
    check("rst_tmo", tmo, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // Invariants sampled away from the active edge.
  logic [N-1:0] pg = '0;
  logic         pt = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      check("onehot0", $onehot0(gnt) ? 1 : 0, 1);
      check("tmo_twice", (pt && tmo) ? 1 : 0, 0);
      check("direct_handover", (pg != 0 && gnt != 0 && gnt != pg) ? 1 : 0, 0);
    end
    pg = gnt;
    pt = tmo;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] g;
    logic [1:0]   id;
    logic         t;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int hi, guard, own, tmo_early;
    logic [N-1:0] r;
    int order[$];

    tbl[0]  = '{3'b010, 3'b000, 2'd0, 1'b0};
    tbl[1]  = '{3'b010, 3'b010, 2'd1, 1'b0};
    tbl[2]  = '{3'b010, 3'b010, 2'd1, 1'b0};
    tbl[3]  = '{3'b010, 3'b010, 2'd1, 1'b0};
    tbl[4]  = '{3'b010, 3'b010, 2'd1, 1'b0};
    tbl[5]  = '{3'b010, 3'b010, 2'd1, 1'b0};
    tbl[6]  = '{3'b000, 3'b000, 2'd0, 1'b0};
    tbl[7]  = '{3'b000, 3'b000, 2'd0, 1'b0};
    tbl[8]  = '{3'b101, 3'b100, 2'd2, 1'b0};
    tbl[9]  = '{3'b111, 3'b100, 2'd2, 1'b0};
    tbl[10] = '{3'b011, 3'b000, 2'd0, 1'b0};
    tbl[11] = '{3'b011, 3'b000, 2'd0, 1'b0};
    tbl[12] = '{3'b011, 3'b001, 2'd0, 1'b0};
    tbl[13] = '{3'b010, 3'b000, 2'd0, 1'b0};
    tbl[14] = '{3'b010, 3'b000, 2'd0, 1'b0};
    tbl[15] = '{3'b010, 3'b010, 2'd1, 1'b0};
    tbl[16] = '{3'b000, 3'b000, 2'd0, 1'b0};

    repeat (2) @(posedge clk);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r);
      check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
      check($sformatf("tbl%0d_id", i), gnt_id, tbl[i].id);
      check($sformatf("tbl%0d_busy", i), busy, (tbl[i].g != 0) ? 1 : 0);
      check($sformatf("tbl%0d_tmo", i), tmo, tbl[i].t);
    end

    // Sole requester held forever: 16-cycle grant, revoke, gap, regrant.
    do_reset();
    step(3'b001);
    check("to_first_edge", gnt, 0);
    step(3'b001);
    check("to_grant", gnt, 3'b001);
    hi = 0; guard = 0; tmo_early = 0;
    while (gnt == 3'b001 && guard < 40) begin
      hi++;
      if (tmo) tmo_early++;
      step(3'b001);
      guard++;
    end
    check("to_len", hi, MH);
    check("to_early_tmo", tmo_early, 0);
    check("to_pulse", tmo, 1);
    check("to_gap", gnt, 0);
    step(3'b001);
    check("to_idle_gnt", gnt, 0);
    check("to_idle_tmo", tmo, 0);
    step(3'b001);
    check("to_regrant", gnt, 3'b001);

    // Timeout under contention: next owner is requester 1.
    do_reset();
    step(3'b011);
    step(3'b011);
    check("ct_grant0", gnt, 3'b001);
    guard = 0;
    while (gnt == 3'b001 && guard < 40) begin
      step(3'b011);
      guard++;
    end
    check("ct_tmo", tmo, 1);
    step(3'b011);
    check("ct_idle", gnt, 0);
    step(3'b011);
    check("ct_next", gnt, 3'b010);
    check("ct_next_id", gnt_id, 1);

    // Fairness: every owner drops req for one cycle after owning for three.
    do_reset();
    own = 0; guard = 0;
    order.delete();
    while (order.size() < 6 && guard < 200) begin
      r = 3'b111;
      if (gnt != 0 && own == 3) r = 3'b111 & ~gnt;
      step(r);
      if (gnt != 0) begin
        if (own == 0) begin
          order.push_back(int'(gnt_id));
          own = 1;
        end else own++;
      end else own = 0;
      guard++;
    end
    check("fair_count", order.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) check($sformatf("fair_order%0d", i), order[i], i % 3);

    // Reset during a grant to requester 2.
    do_reset();
    guard = 0;
    step(3'b100);
    while (gnt != 3'b100 && guard < 10) begin
      step(3'b100);
      guard++;
    end
    check("mr_owned", gnt, 3'b100);
    #2;
    rst = 1'b0;
    #1;
    check("mr_gnt", gnt, 0);
    check("mr_id", gnt_id, 0);
    check("mr_busy", busy, 0);
    check("mr_tmo", tmo, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    step(3'b111);
    check("mr_first_edge", gnt, 0);
    step(3'b111);
    check("mr_first_grant", gnt, 3'b001);

    // Random traffic against the model, with occasional resets.
    do_reset();
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(15) == 0) r[b] = ~r[b];
      if ($urandom_range(999) == 0) begin
        do_reset();
      end
      step(r);
      check("rnd_gnt", gnt, (m_owner >= 0) ? (1 << m_owner) : 0);
      check("rnd_id", gnt_id, (m_owner >= 0) ? m_owner : 0);
      check("rnd_busy", busy, (m_owner >= 0) ? 1 : 0);
      check("rnd_tmo", tmo, m_tmo);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shared_res_sched.md
SHARED_RES_SCHED -- requirements
Module: shared_res_sched

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters; legal range 2..4.
REQ-002 Parameter MAX_HOLD, default 16: maximum grant length in cycles; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 req  input  N_REQ  level request per requester; held high while the requester wants or uses the resource.
REQ-006 gnt  output  N_REQ  one-hot grant; at most one bit high.
REQ-007 gnt_id  output  2  binary index of the current owner; 0 when no grant is active.
REQ-008 busy  output  1  high while any gnt bit is high.
REQ-009 tmo  output  1  one-cycle pulse when a grant is force-revoked.

Function
REQ-010 FSM states: IDLE, OWN, GAP; all outputs registered.
REQ-011 IDLE: if any req bit is high, select the winner by round-robin from the pointer, assert its gnt bit next cycle, then go to OWN; otherwise stay in IDLE.
REQ-012 Round-robin: search order starts at (last_owner+1) mod N_REQ and wraps; after reset last_owner = N_REQ-1, so requester 0 has first priority.
REQ-013 last_owner updates to the winner's index on the cycle the grant is issued.
REQ-014 OWN: a hold counter clears on grant entry and increments each cycle the owner's req stays high.
REQ-015 OWN: owner req low -> deassert gnt next cycle, go to GAP, tmo stays 0.
REQ-016 OWN: counter reaches MAX_HOLD-1 with owner req still high -> deassert gnt next cycle, pulse tmo for one cycle, go to GAP.
REQ-017 GAP: exactly one cycle with gnt all zero, then return to IDLE; the arbitration decision is made in IDLE, so the minimum owner-to-owner turnaround is 2 idle cycles.
REQ-018 A requester revoked by timeout that still holds req is re-eligible at its normal round-robin position; it receives no extra priority and no penalty.
REQ-019 req changes on non-owners during OWN or GAP have no effect on the current grant.
REQ-020 Simultaneous owner release and timeout threshold in the same cycle: treat as a normal release; tmo stays 0.
REQ-021 gnt_id always equals the encoded index of gnt; busy equals OR of gnt.
REQ-022 Max grant length = MAX_HOLD cycles; counter width = ceil(log2(MAX_HOLD)) bits; the counter must not wrap.

Reset
REQ-023 rst low asynchronously forces gnt=0, gnt_id=0, busy=0, tmo=0, state=IDLE, counter=0, last_owner=N_REQ-1.
REQ-024 Reset asserted during OWN drops gnt immediately, with no tmo pulse.
REQ-025 After rst rises, the first grant is issued no earlier than the second rising clk edge.

Verification
REQ-026 Single requester: req=3'b010 held 5 cycles after grant, then low -> gnt=3'b010 for 5 cycles, gnt_id=1, one GAP cycle, tmo never high.
REQ-027 Fairness: req=3'b111 held constant, each owner drops req for 1 cycle after 3 cycles of ownership -> grant order 0,1,2,0,1,2; no requester skipped.
REQ-028 Timeout: MAX_HOLD=16, req[0] held high permanently -> gnt[0] high exactly 16 cycles, tmo pulses once, GAP follows, then gnt[0] is regranted if it is the only requester.
REQ-029 Timeout with contention: req=3'b011 held, requester 0 times out -> next grant goes to 1, not 0.
REQ-030 Reset mid-grant: rst low while gnt=3'b100 -> gnt=0 with no clock edge; after release, req=3'b111 -> first grant is 3'b001.
REQ-031 Assertions throughout all tests: gnt is one-hot or zero; tmo is never high for two consecutive cycles; gnt never moves directly from one owner to another without at least one all-zero cycle.
